sec32_scrub_ctrl: RTL and testbench

//   Background scrubber for a 32-bit SEC-protected memory (32 data + 8 check bits). It walks addresses
//   0..DEPTH-1, reads each word and presents data and check bits to the external combinational SEC

---
 rtl/sec32_scrub_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sec32_scrub_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec32_scrub_ctrl.sv
// sec32_scrub_ctrl
//   Background scrubber for a 32-bit SEC-protected memory (32 data + 8 check
//   bits). Walks addresses 0..DEPTH-1, one word every INTERVAL idle cycles,
//   reads the word, presents it to the external combinational SEC corrector
//   and writes back any word the corrector changes. Corrections are counted
//   in a saturating counter.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   enable                level, scrubbing allowed
//   clr_count             pulse, clears corr_count (wins over an increment)
//   mem_req/mem_we        memory request and direction (1 = write)
//   mem_addr/mem_wdata    word address and write data
//   mem_ack               one-cycle completion, mem_rdata/mem_rchk valid with it
//   cor_en/cor_din/cor_chk  corrector inputs, held from read capture to NEXT
//   cor_dout              corrected data, combinational from the corrector
//   busy                  a word scrub is in progress (not IDLE or WAIT)
//   pass_done             one-cycle pulse after the last address is processed
//   corr_count            saturating count of corrected words
//   dbg_state             current FSM state
//
// Memory handshake: mem_req is high for the whole of READ and WRITE; mem_we,
// mem_addr and mem_wdata are registers that do not change in those states,
// so the request is stable until the cycle mem_ack is seen. The FSM leaves
// the state on that edge, so mem_req drops the cycle after mem_ack and a
// read is never followed directly by a write without CHECK in between.

module sec32_scrub_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int INTERVAL = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clr_count,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic [7:0]        mem_rchk,
  output logic              cor_en,
  output logic [31:0]       cor_din,
  output logic [7:0]        cor_chk,
  input  logic [31:0]       cor_dout,
  output logic              busy,
  output logic              pass_done,
  output logic [CNT_W-1:0]  corr_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5
  } state_e;

  localparam int                TMR_W     = $clog2(INTERVAL + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cor_en_q, cor_en_d;
  logic [31:0]       cor_din_q, cor_din_d;
  logic [7:0]        cor_chk_q, cor_chk_d;
  logic [CNT_W-1:0]  corr_count_q, corr_count_d;
  logic              pass_done_q, pass_done_d;
  // Remembers that enable dropped while a word was in flight, so the word is
  // finished and the FSM then parks in IDLE even if enable came back.
  logic              stop_q, stop_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cor_en_d     = cor_en_q;
    cor_din_d    = cor_din_q;
    cor_chk_d    = cor_chk_q;
    corr_count_d = corr_count_q;
    pass_done_d  = 1'b0;
    stop_d       = stop_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT;
          timer_d = TMR_LOAD;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_READ;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          cor_din_d = mem_rdata;
          cor_chk_d = mem_rchk;
          cor_en_d  = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        // A check-bit-only error leaves the data unchanged: no write-back.
        mem_wdata_d = cor_dout;
        state_d     = (cor_dout != cor_din_q) ? S_WRITE : S_NEXT;
      end
      S_WRITE: begin
        if (mem_ack) begin
          if (corr_count_q != CNT_MAX) begin
            corr_count_d = corr_count_q + 1'b1;
          end
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        cor_en_d = 1'b0;
        if (mem_addr_q == LAST_ADDR) begin
          mem_addr_d  = '0;
          pass_done_d = 1'b1;
        end else begin
          mem_addr_d = mem_addr_q + 1'b1;
        end
        timer_d = TMR_LOAD;
        state_d = (stop_q || !enable) ? S_IDLE : S_WAIT;
        stop_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!enable && (state_q == S_READ || state_q == S_CHECK || state_q == S_WRITE)) begin
      stop_d = 1'b1;
    end

    if (clr_count) begin
      corr_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cor_en_q     <= 1'b0;
      cor_din_q    <= '0;
      cor_chk_q    <= '0;
      corr_count_q <= '0;
      pass_done_q  <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cor_en_q     <= cor_en_d;
      cor_din_q    <= cor_din_d;
      cor_chk_q    <= cor_chk_d;
      corr_count_q <= corr_count_d;
      pass_done_q  <= pass_done_d;
      stop_q       <= stop_d;
    end
  end

  // Request outputs decode straight from the state register so an
  // asynchronous reset drops mem_req immediately.
  assign mem_req    = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cor_en     = cor_en_q;
  assign cor_din    = cor_din_q;
  assign cor_chk    = cor_chk_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_WAIT);
  assign pass_done  = pass_done_q;
  assign corr_count = corr_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sec32_scrub_ctrl.sv
// tb_sec32_scrub_ctrl
//   Bench for sec32_scrub_ctrl with DEPTH=4, INTERVAL=2, CNT_W=2. Holds a
//   memory with a simple SEC code, a combinational corrector for that code,
//   and a word-level model of what a scrub pass must do: every word is read
//   in address order, and a word whose stored data differs from its golden
//   value must be written back with the golden value and counted.

`timescale 1ns/100ps

module tb_sec32_scrub_ctrl;

  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 4;
  localparam int INTERVAL = 2;
  localparam int CNT_W    = 2;
  localparam int TW       = 1 + ADDR_W + 32;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              enable, clr_count;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [7:0]        mem_rchk;
  logic              cor_en;
  logic [31:0]       cor_din, cor_dout;
  logic [7:0]        cor_chk;
  logic              busy, pass_done;
  logic [CNT_W-1:0]  corr_count;
  logic [2:0]        dbg_state;

  sec32_scrub_ctrl #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_count(clr_count),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rchk(mem_rchk),
    .cor_en(cor_en), .cor_din(cor_din), .cor_chk(cor_chk), .cor_dout(cor_dout),
    .busy(busy), .pass_done(pass_done), .corr_count(corr_count), .dbg_state(dbg_state)
  );

  // SEC code: data bit n has the n-th non-power-of-two column value (3,5,6,7,9..).
  function automatic logic [7:0] enc(input logic [31:0] d);
    logic [7:0] c;
    int n;
    c = '0;
    n = 0;
    for (int v = 3; n < 32; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (d[n]) c = c ^ 8'(v);
        n++;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] sec_correct(input logic [31:0] d, input logic [7:0] chk,
                                              input logic en);
    logic [7:0] s;
    int n;
    if (!en) return d;
    s = chk ^ enc(d);
    n = 0;
    for (int v = 3; n < 32; v++) begin
      if ((v & (v - 1)) != 0) begin
        if (s == 8'(v)) return d ^ (32'h1 << n);
        n++;
      end
    end
    return d;
  endfunction

  assign cor_dout = sec_correct(cor_din, cor_chk, cor_en);

  // memory, golden contents and model state
  logic [31:0] mem_d [DEPTH];
  logic [7:0]  mem_c [DEPTH];
  logic [31:0] gold  [DEPTH];
  bit          dirty [DEPTH];
  int          ack_dly, wcnt;

  logic [TW-1:0] exp_q[$];
  int mdl_ptr, exp_count;
  int reads_seen, writes_seen, pass_cnt;
  int total, bad;

  // scoreboard bookkeeping for the compare process
  bit                prev_pend, prev_pd;
  logic              prev_we;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout_%s actual=expired required=event at %0t", name, $time);
  endtask

  // Expected transactions for the next word the model says gets scrubbed.
  task automatic gen_word();
    exp_q.push_back({1'b0, ADDR_W'(mdl_ptr), 32'h0});
    if (dirty[mdl_ptr]) begin
      exp_q.push_back({1'b1, ADDR_W'(mdl_ptr), gold[mdl_ptr]});
      dirty[mdl_ptr] = 1'b0;
    end
    mdl_ptr = (mdl_ptr + 1) % DEPTH;
  endtask

  function automatic bit cond(input int what);
    case (what)
      0: return pass_done;
      1: return mem_req && mem_we;
      2: return !busy;
      3: return mem_req && (mem_addr == 3'd1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int what, input string name);
    int n;
    for (n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (cond(what)) break;
    end
    if (n == 400) timeout(name);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cor_en"}, cor_en, 0);
    check({tag, "_cor_din"}, cor_din, 0);
    check({tag, "_cor_chk"}, cor_chk, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pass_done"}, pass_done, 0);
    check({tag, "_corr_count"}, corr_count, 0);
  endtask

  task automatic clear_phase();
    reads_seen  = 0;
    writes_seen = 0;
    pass_cnt    = 0;
  endtask

  task automatic phase_end(input string tag, input int rd, input int wr, input int pc);
    check({tag, "_reads"}, reads_seen, rd);
    check({tag, "_writes"}, writes_seen, wr);
    check({tag, "_passes"}, pass_cnt, pc);
    check({tag, "_sb_left"}, exp_q.size(), 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_req"}, mem_req, 0);
  endtask

  task automatic run_pass(input string tag, input int rd, input int wr);
    clear_phase();
    enable = 1'b1;
    wait_for(0, tag);
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    phase_end(tag, rd, wr, 1);
  endtask

  task automatic pulse_clr();
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
  endtask

  initial begin
    int n;
    bit seen_low;
    total = 0; bad = 0;
    gold[0] = 32'h1234_5678; gold[1] = 32'hDEAD_BEEF;
    gold[2] = 32'h0F0F_F0F0; gold[3] = 32'hCAFE_0001;
    for (int a = 0; a < DEPTH; a++) begin
      mem_d[a] = gold[a];
      mem_c[a] = enc(gold[a]);
      dirty[a] = 1'b0;
    end
    enable = 1'b0; clr_count = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; mem_rchk = '0;
    ack_dly = 1; wcnt = 0;
    mdl_ptr = 0; exp_count = 0;
    prev_pend = 0; prev_pd = 0; prev_we = 0; prev_addr = '0; prev_wdata = '0;
    clear_phase();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_vals("por");

    fork
      // memory responder: ack after ack_dly cycles of a visible request
      forever begin
        @(posedge clk);
        #1;
        if (!rst_n || !mem_req || mem_ack) begin
          mem_ack = 1'b0;
          wcnt    = 0;
        end else if (wcnt == ack_dly) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_d[int'(mem_addr) % DEPTH] = mem_wdata;
            mem_c[int'(mem_addr) % DEPTH] = enc(mem_wdata);
          end else begin
            mem_rdata = mem_d[int'(mem_addr) % DEPTH];
            mem_rchk  = mem_c[int'(mem_addr) % DEPTH];
          end
        end else begin
          wcnt++;
        end
      end
      // compare process: sampled mid-cycle, transactions complete at the next edge
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          mdl_ptr = 0; exp_count = 0; prev_pend = 0; prev_pd = 0;
          continue;
        end
        check("corr_count", corr_count, exp_count);
        if (prev_pend) begin
          check("hold_req", mem_req, 1);
          check("hold_we", mem_we, prev_we);
          check("hold_addr", mem_addr, prev_addr);
          check("hold_wdata", mem_wdata, prev_wdata);
        end
        if (mem_req) check("busy_with_req", busy, 1);
        if (pass_done) begin
          pass_cnt++;
          check("pass_done_width", prev_pd, 0);
          check("pass_wrap_ptr", mdl_ptr, 0);
          check("pass_word_done", exp_q.size(), 0);
        end
        prev_pd = pass_done;
        if (mem_req && mem_ack) begin
          logic [TW-1:0] t;
          if (exp_q.size() == 0) gen_word();
          t = exp_q.pop_front();
          check("txn_we", mem_we, t[TW-1]);
          check("txn_addr", mem_addr, t[TW-2 -: ADDR_W]);
          if (mem_we) begin
            check("txn_wdata", mem_wdata, t[31:0]);
            writes_seen++;
            exp_count = (exp_count >= CNT_SAT) ? CNT_SAT : exp_count + 1;
          end else begin
            reads_seen++;
          end
        end
        if (clr_count) exp_count = 0;
        prev_pend  = mem_req && !mem_ack;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
      end
      begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // clean pass: latency to first request and read-to-read period
    @(posedge clk);
    #1;
    clear_phase();
    enable = 1'b1;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (mem_req) break;
    end
    check("enable_to_req", n, INTERVAL + 1);
    seen_low = 0;
    for (n = 1; n <= 50; n++) begin
      @(posedge clk);
      #1;
      if (!mem_req) seen_low = 1;
      else if (seen_low) break;
    end
    check("read_period", n, 6);
    wait_for(0, "clean");
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    phase_end("clean", 4, 0, 1);
    check("clean_count", corr_count, 0);

    // data bit 7 of word 2 flipped
    mem_d[2] = gold[2] ^ 32'h80; dirty[2] = 1'b1;
    run_pass("data_err", 4, 1);
    check("data_err_count", corr_count, 1);
    check("data_err_fixed", mem_d[2], gold[2]);
    pulse_clr();
    check("clr_count", corr_count, 0);

    // check bit 3 of word 1 flipped: data fine, nothing written
    mem_c[1] = mem_c[1] ^ 8'h08;
    run_pass("chk_err", 4, 0);
    check("chk_err_count", corr_count, 0);

    // enable dropped during a slow write: word finishes, FSM parks, resumes at addr+1
    mem_c[1] = enc(gold[1]); mem_d[1] = gold[1] ^ 32'h1; dirty[1] = 1'b1;
    ack_dly = 5;
    clear_phase();
    enable = 1'b1;
    wait_for(1, "abort_write");
    enable = 1'b0;
    wait_for(2, "abort_idle");
    repeat (6) @(posedge clk);
    #1;
    phase_end("abort", 2, 1, 0);
    check("abort_addr", mem_addr, 2);
    check("abort_count", corr_count, 1);
    check("abort_fixed", mem_d[1], gold[1]);
    ack_dly = 1;
    run_pass("resume", 2, 0);

    // every word corrupted: counter saturates
    pulse_clr();
    for (int a = 0; a < DEPTH; a++) begin
      mem_d[a] = gold[a] ^ (32'h1 << (a * 3 + 4));
      dirty[a] = 1'b1;
    end
    run_pass("saturate", 4, 4);
    check("saturate_count", corr_count, CNT_SAT);
    for (int a = 0; a < DEPTH; a++) check("saturate_fixed", mem_d[a], gold[a]);

    // clr_count on the very cycle a write is acknowledged
    mem_d[0] = gold[0] ^ 32'h8000_0000; dirty[0] = 1'b1;
    ack_dly = 3;
    clear_phase();
    enable = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      #2;
      if (mem_req && mem_we && mem_ack) break;
    end
    if (n == 100) timeout("clr_on_ack");
    pulse_clr();
    check("clr_on_ack_count", corr_count, 0);
    check("clr_on_ack_writes", writes_seen, 1);
    wait_for(0, "clr_pass");
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    phase_end("clr_pass", 4, 1, 1);
    check("clr_pass_count", corr_count, 0);

    // asynchronous reset while a read to address 1 is outstanding
    ack_dly = 1;
    enable = 1'b1;
    wait_for(3, "reset_read");
    ack_dly = 20;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    ack_dly = 1;
    repeat (2) @(posedge clk);
    #1;
    clear_phase();
    rst_n = 1'b1;
    wait_for(0, "after_reset");
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    phase_end("after_reset", 4, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
